// File: rtl/exu_wb_buffer_if.sv
// Bundle of the ALU-result input handshake, the writeback output handshake
// and the fetch redirect of the execute/writeback buffer.
interface exu_wb_buffer_if;
    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both 1; valid must not depend combinationally on ready.
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_zero;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic        in_rf_wen;
    logic [2:0]  in_br_type;
    logic        in_jalr;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_wdata;
    logic        out_wen;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Producer / consumer side (ALU stage plus writeback stage).
    modport master (
        output in_valid, in_result, in_zero, in_pc, in_imm, in_rd,
               in_rf_wen, in_br_type, in_jalr, out_ready,
        input  in_ready, out_valid, out_rd, out_wdata, out_wen,
               redirect_valid, redirect_pc
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_result, in_zero, in_pc, in_imm, in_rd,
               in_rf_wen, in_br_type, in_jalr, out_ready,
        output in_ready, out_valid, out_rd, out_wdata, out_wen,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exu_wb_buffer.sv
// Two-entry FIFO between the ALU and register-file writeback; resolves
// branches/jumps on entry and emits a one-cycle fetch redirect when taken.
module exu_wb_buffer (
    input  logic           clk,
    input  logic           rst_n,
    exu_wb_buffer_if.slave wb
);

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;
    localparam logic [2:0] BR_JUMP = 3'd7;

    logic [1:0]  count;
    logic [4:0]  slot0_rd,    slot1_rd;
    logic [31:0] slot0_wdata, slot1_wdata;
    logic        slot0_wen,   slot1_wen;

    logic        push;
    logic        pop;
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
    logic [31:0] new_wdata;
    logic        new_wen;

    // Ready and valid come purely from the registered occupancy count.
    assign wb.in_ready  = (count != 2'd2);
    assign wb.out_valid = (count != 2'd0);

    assign push = wb.in_valid  & wb.in_ready;
    assign pop  = wb.out_valid & wb.out_ready;

    // Branch resolution on the incoming entry; slt result lives in bit 0.
    always_comb begin
        taken = 1'b0;
        case (wb.in_br_type)
            BR_NONE:         taken = 1'b0;
            BR_BEQ:          taken = wb.in_zero;
            BR_BNE:          taken = ~wb.in_zero;
            BR_BLT, BR_BLTU: taken = wb.in_result[0];
            BR_BGE, BR_BGEU: taken = ~wb.in_result[0];
            BR_JUMP:         taken = 1'b1;
            default:         taken = 1'b0;
        endcase
    end

    assign is_jump   = (wb.in_br_type == BR_JUMP);
    assign target    = (is_jump && wb.in_jalr) ? {wb.in_result[31:1], 1'b0}
                                               : wb.in_pc + wb.in_imm;
    assign new_wdata = is_jump ? wb.in_pc + 32'd4 : wb.in_result;
    // Conditional branches never write; x0 writes are dropped here.
    assign new_wen   = wb.in_rf_wen & (is_jump | (wb.in_br_type == BR_NONE))
                       & (wb.in_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count          <= 2'd0;
            slot0_rd       <= 5'd0;
            slot0_wdata    <= 32'd0;
            slot0_wen      <= 1'b0;
            slot1_rd       <= 5'd0;
            slot1_wdata    <= 32'd0;
            slot1_wen      <= 1'b0;
            wb.redirect_valid <= 1'b0;
            wb.redirect_pc    <= 32'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (pop && count == 2'd2) begin
                slot0_rd    <= slot1_rd;
                slot0_wdata <= slot1_wdata;
                slot0_wen   <= slot1_wen;
            end

            // New entry lands in slot0 if the buffer is (or becomes) empty.
            if (push) begin
                if (count == 2'd0 || pop) begin
                    slot0_rd    <= wb.in_rd;
                    slot0_wdata <= new_wdata;
                    slot0_wen   <= new_wen;
                end else begin
                    slot1_rd    <= wb.in_rd;
                    slot1_wdata <= new_wdata;
                    slot1_wen   <= new_wen;
                end
            end

            wb.redirect_valid <= push & taken;
            wb.redirect_pc    <= (push & taken) ? target : 32'd0;
        end
    end

    assign wb.out_rd    = wb.out_valid ? slot0_rd    : 5'd0;
    assign wb.out_wdata = wb.out_valid ? slot0_wdata : 32'd0;
    assign wb.out_wen   = wb.out_valid ? slot0_wen   : 1'b0;

endmodule
